// File: rtl/muldiv_pkg.sv
// Shared width, operation codes and FSM states for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int WIDTH = 16;

  typedef enum logic [1:0] {
    MULL = 2'd0,
    MULH = 2'd1,
    DIV  = 2'd2,
    MOD  = 2'd3
  } op_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  function automatic logic op_is_div(input op_t o);
    return o[1];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide, purely combinational.
module muldiv_step #(
  parameter int W = 16
) (
  input  logic [2*W-1:0] acc,
  input  logic [W-1:0]   operand,
  input  logic           in_bit,
  input  logic [1:0]     op,
  output logic [2*W-1:0] acc_next,
  output logic           q_bit
);
  import muldiv_pkg::*;

  logic [W:0]   rem_sh;
  logic [W-1:0] rem_new;

  always_comb begin
    acc_next = '0;
    q_bit    = 1'b0;
    rem_sh   = {acc[W-1:0], in_bit};
    rem_new  = rem_sh[W-1:0];
    if (op_is_div(op_t'(op))) begin
      // Remainder is W+1 bits after the shift; subtract only when it covers the divisor.
      q_bit    = (rem_sh >= {1'b0, operand});
      if (q_bit)
        rem_new = W'(rem_sh - {1'b0, operand});
      acc_next = {acc[2*W-1:W], rem_new};
    end else begin
      acc_next = {acc[2*W-2:0], 1'b0} + {{W{1'b0}}, operand};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide: WIDTH cycles per operation, one cycle for divide-by-zero.
module muldiv_unit #(
  parameter int WIDTH = muldiv_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  output logic [WIDTH-1:0] muldiv,
  output logic             busy,
  output logic             done,
  output logic             divzero
);
  import muldiv_pkg::*;

  localparam int CW = $clog2(WIDTH);

  state_t             state, state_next;
  op_t                op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [CW-1:0]      cnt, bit_idx;
  logic [2*WIDTH-1:0] acc, acc_step, acc_upd;
  logic [WIDTH-1:0]   step_operand;
  logic               q_bit, is_div, div_zero, last, finish;

  assign is_div   = op_is_div(op_q);
  assign div_zero = is_div && (b_q == '0);
  assign last     = (cnt == CW'(WIDTH - 1));
  assign finish   = (state == S_RUN) && (div_zero || last);
  assign bit_idx  = CW'(WIDTH - 1) - cnt;
  assign busy     = (state == S_RUN);

  // Operands are consumed MSB first: multiplier bit gates the addend, dividend bit feeds the remainder.
  assign step_operand = is_div ? b_q : (b_q[bit_idx] ? a_q : '0);

  muldiv_step #(.W(WIDTH)) u_step (
    .acc      (acc),
    .operand  (step_operand),
    .in_bit   (a_q[bit_idx]),
    .op       (op_q),
    .acc_next (acc_step),
    .q_bit    (q_bit)
  );

  // Quotient bits accumulate in the upper half while the remainder lives in the lower half.
  assign acc_upd = is_div ? {acc_step[2*WIDTH-2:WIDTH], q_bit, acc_step[WIDTH-1:0]} : acc_step;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start)  state_next = S_RUN;
      S_RUN:  if (finish) state_next = S_IDLE;
      default:            state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= MULL;
      a_q     <= '0;
      b_q     <= '0;
      cnt     <= '0;
      acc     <= '0;
      muldiv  <= '0;
      done    <= 1'b0;
      divzero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == S_IDLE && start) begin
        op_q <= op_t'(op);
        a_q  <= num1;
        b_q  <= num2;
        cnt  <= '0;
        acc  <= '0;
      end else if (state == S_RUN) begin
        if (div_zero) begin
          muldiv  <= (op_q == DIV) ? '1 : a_q;
          divzero <= 1'b1;
          done    <= 1'b1;
        end else begin
          acc <= acc_upd;
          cnt <= cnt + 1'b1;
          if (last) begin
            muldiv  <= (op_q == MULL || op_q == MOD) ? acc_upd[WIDTH-1:0]
                                                     : acc_upd[2*WIDTH-1:WIDTH];
            divzero <= 1'b0;
            done    <= 1'b1;
          end
        end
      end
    end
  end

endmodule
